// File: rtl/mem_pkg.sv
// Shared types and address helpers for the two-port memory responder.
package mem_pkg;

   localparam int unsigned WORD_W = 64;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      PORT1 = 1'b0,
      PORT2 = 1'b1
   } owner_e;

   // Word index relative to the store base; the byte offset within a word is dropped.
   function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr,
                                                    input logic [WORD_W-1:0] base);
      return (addr - base) >> 3;
   endfunction

   function automatic logic in_range(input logic [WORD_W-1:0] addr,
                                     input logic [WORD_W-1:0] base,
                                     input logic [WORD_W-1:0] depth);
      return (addr >= base) && (word_index(addr, base) < depth);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Backing store: one synchronous write port, one combinational read port.
module mem_array
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned AW          = 12
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_idx,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_idx,
   output logic [WORD_W-1:0] rd_data_c
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   // Contents deliberately survive reset so preloaded data stays valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/mem_responder.sv
// Two-port read responder with fixed port-1 priority, programmable latency and preload writes.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LATENCY     = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req1,
   input  logic [63:0] addr1,
   output logic        stall1,
   output logic [63:0] rdata1,
   input  logic        req2,
   input  logic [63:0] addr2,
   output logic        stall2,
   output logic [63:0] rdata2,
   input  logic        wr_en,
   input  logic [63:0] wr_addr,
   input  logic [63:0] wr_data,
   output logic        err
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH_WORDS);

   state_e            state_q, state_d;
   owner_e            owner_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              pend1_q, pend2_q;
   logic [63:0]       addr1_q, addr2_q, cur_addr_q;
   logic [63:0]       rdata1_q, rdata2_q;
   logic              err_q;

   logic              acc1_c, acc2_c, drop1_c, drop2_c;
   logic              want1_c, want2_c, cand1_c, cand2_c;
   logic              grant_c, read_c, done_c;
   owner_e            grant_port_c;
   logic [63:0]       grant_addr_c;
   logic              rd_ok_c, wr_ok_c;
   logic [WORD_W-1:0] mem_rdata_c, rd_val_c;

   // A request is taken only when its slot is free; a busy slot drops it.
   assign acc1_c  = req1 & ~pend1_q;
   assign acc2_c  = req2 & ~pend2_q;
   assign drop1_c = req1 &  pend1_q;
   assign drop2_c = req2 &  pend2_q;
   // A freshly accepted request is grantable in the same cycle it arrives.
   assign want1_c = pend1_q | acc1_c;
   assign want2_c = pend2_q | acc2_c;

   assign rd_ok_c  = in_range(cur_addr_q, BASE_ADDR, DEPTH_W);
   assign wr_ok_c  = in_range(wr_addr, BASE_ADDR, DEPTH_W);
   assign rd_val_c = rd_ok_c ? mem_rdata_c : '0;

   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_mem_array (
      .clk       (clk),
      .wr_en     (wr_en & wr_ok_c),
      .wr_idx    (AW'(word_index(wr_addr, BASE_ADDR))),
      .wr_data   (wr_data),
      .rd_idx    (AW'(word_index(cur_addr_q, BASE_ADDR))),
      .rd_data_c (mem_rdata_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant_c) state_d = ACCESS;
         ACCESS:  if (read_c)  state_d = DONE;
         DONE:    state_d = grant_c ? ACCESS : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant arbitration and per-state strobes; in DONE the current owner is not a candidate.
   always_comb begin
      grant_c      = 1'b0;
      grant_port_c = PORT1;
      grant_addr_c = '0;
      read_c       = 1'b0;
      done_c       = 1'b0;
      cand1_c      = 1'b0;
      cand2_c      = 1'b0;
      unique case (state_q)
         IDLE: begin
            cand1_c = want1_c;
            cand2_c = want2_c;
         end
         ACCESS: read_c = (cnt_q == '0);
         DONE: begin
            done_c  = 1'b1;
            cand1_c = want1_c & (owner_q != PORT1);
            cand2_c = want2_c & (owner_q != PORT2);
         end
         default: ;
      endcase
      if (cand1_c) begin
         grant_c      = 1'b1;
         grant_port_c = PORT1;
         grant_addr_c = pend1_q ? addr1_q : addr1;
      end else if (cand2_c) begin
         grant_c      = 1'b1;
         grant_port_c = PORT2;
         grant_addr_c = pend2_q ? addr2_q : addr2;
      end
   end

   // Slots, counter, owner and read-data registers; memory is untouched by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend1_q    <= 1'b0;
         pend2_q    <= 1'b0;
         addr1_q    <= '0;
         addr2_q    <= '0;
         cur_addr_q <= '0;
         owner_q    <= PORT1;
         cnt_q      <= '0;
         rdata1_q   <= '0;
         rdata2_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         pend1_q <= (pend1_q & ~(done_c & (owner_q == PORT1))) | acc1_c;
         pend2_q <= (pend2_q & ~(done_c & (owner_q == PORT2))) | acc2_c;
         if (acc1_c) addr1_q <= addr1;
         if (acc2_c) addr2_q <= addr2;
         if (grant_c) begin
            owner_q    <= grant_port_c;
            cur_addr_q <= grant_addr_c;
            cnt_q      <= CNT_W'(LATENCY - 1);
         end else if (state_q == ACCESS && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (read_c && owner_q == PORT1) rdata1_q <= rd_val_c;
         if (read_c && owner_q == PORT2) rdata2_q <= rd_val_c;
         err_q <= err_q | drop1_c | drop2_c | (read_c & ~rd_ok_c) | (wr_en & ~wr_ok_c);
      end
   end

   assign stall1 = pend1_q;
   assign stall2 = pend2_q;
   assign rdata1 = rdata1_q;
   assign rdata2 = rdata2_q;
   assign err    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, arbitration, drops, range errors, reset and write/read ordering.
module tb_mem_responder;

   localparam logic [63:0] W0 = 64'hDEAD_BEEF_0000_0001;
   localparam logic [63:0] A1 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] A2 = 64'h5555_6666_7777_8888;
   localparam logic [63:0] W3 = 64'hAAAA_BBBB_CCCC_DDDD;
   localparam logic [63:0] N3 = 64'h0123_4567_89AB_CDEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        req1, req2, wr_en;
   logic [63:0] addr1, addr2, wr_addr, wr_data;
   logic        stall1, stall2, err;
   logic [63:0] rdata1, rdata2;

   int checks = 0;
   int errors = 0;
   int f1, f2;

   mem_responder #(
      .DEPTH_WORDS (16),
      .LATENCY     (2),
      .BASE_ADDR   (64'h0)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req1    (req1),
      .addr1   (addr1),
      .stall1  (stall1),
      .rdata1  (rdata1),
      .req2    (req2),
      .addr2   (addr2),
      .stall2  (stall2),
      .rdata2  (rdata2),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [63:0] a, input logic [63:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   // Requests are already driven in cycle 0; returns the first cycle each stall reads low.
   task automatic measure(output int fa, output int fb);
      fa = -1;
      fb = -1;
      for (int k = 1; k <= 12; k++) begin
         step();
         req1 = 1'b0;
         req2 = 1'b0;
         if (fa < 0 && !stall1) fa = k;
         if (fb < 0 && !stall2) fb = k;
      end
   endtask

   initial begin
      rst = 1'b0; req1 = 1'b0; req2 = 1'b0; wr_en = 1'b0;
      addr1 = '0; addr2 = '0; wr_addr = '0; wr_data = '0;
      step();
      step();
      chk("reset_stall1", 64'(stall1), 64'd0);
      chk("reset_stall2", 64'(stall2), 64'd0);
      chk("reset_rdata1", rdata1, 64'h0);
      chk("reset_rdata2", rdata2, 64'h0);
      chk("reset_err", 64'(err), 64'd0);
      rst = 1'b1;
      step();

      preload(64'h00, W0);
      preload(64'h08, A1);
      preload(64'h10, A2);
      preload(64'h18, W3);

      // Single port-1 read: stall high cycles 1-3, low in cycle 4.
      req1 = 1'b1; addr1 = 64'h0;
      chk("p1_stall_c0", 64'(stall1), 64'd0);
      step(); req1 = 1'b0;
      chk("p1_stall_c1", 64'(stall1), 64'd1);
      step();
      chk("p1_stall_c2", 64'(stall1), 64'd1);
      step();
      chk("p1_stall_c3", 64'(stall1), 64'd1);
      step();
      chk("p1_stall_c4", 64'(stall1), 64'd0);
      chk("p1_rdata", rdata1, W0);

      // Simultaneous requests: port 1 first, port 2 three cycles later.
      req1 = 1'b1; addr1 = 64'h08;
      req2 = 1'b1; addr2 = 64'h10;
      measure(f1, f2);
      chk("both_f1", 64'(f1), 64'd4);
      chk("both_f2", 64'(f2), 64'd7);
      chk("both_rdata1", rdata1, A1);
      chk("both_rdata2", rdata2, A2);

      // Write to word 3 in the cycle its read completes: old data returned.
      req1 = 1'b1; addr1 = 64'h18;
      step(); req1 = 1'b0;
      step();
      wr_en = 1'b1; wr_addr = 64'h18; wr_data = N3;
      step(); wr_en = 1'b0;
      step();
      chk("wr_rd_stall", 64'(stall1), 64'd0);
      chk("wr_rd_old", rdata1, W3);
      req1 = 1'b1; addr1 = 64'h18;
      measure(f1, f2);
      chk("wr_rd_new", rdata1, N3);
      chk("p2_untouched", rdata2, A2);
      chk("no_err_yet", 64'(err), 64'd0);

      // Repeated req1 while busy is dropped and flags err.
      req1 = 1'b1; addr1 = 64'h08;
      step(); addr1 = 64'h00;
      chk("drop_stall", 64'(stall1), 64'd1);
      step(); req1 = 1'b0;
      chk("drop_err", 64'(err), 64'd1);
      step();
      step();
      chk("drop_fall", 64'(stall1), 64'd0);
      chk("drop_rdata", rdata1, A1);

      // Out-of-range port-2 read returns zero, sets err, same timing.
      do_reset();
      chk("oor_err_clr", 64'(err), 64'd0);
      req2 = 1'b1; addr2 = 64'h10;
      measure(f1, f2);
      chk("p2_ok_f2", 64'(f2), 64'd4);
      chk("p2_ok_rdata", rdata2, A2);
      req2 = 1'b1; addr2 = 64'h80;
      measure(f1, f2);
      chk("oor_f2", 64'(f2), 64'd4);
      chk("oor_rdata2", rdata2, 64'h0);
      chk("oor_err", 64'(err), 64'd1);

      // Reset during ACCESS abandons the read; memory survives.
      do_reset();
      req1 = 1'b1; addr1 = 64'h08;
      measure(f1, f2);
      chk("pre_rst_rdata", rdata1, A1);
      req1 = 1'b1; addr1 = 64'h18;
      step(); req1 = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_stall", 64'(stall1), 64'd0);
      chk("mid_rst_rdata", rdata1, 64'h0);
      step();
      rst = 1'b1;
      step();
      step();
      step();
      chk("post_rst_stall", 64'(stall1), 64'd0);
      chk("post_rst_rdata", rdata1, 64'h0);
      req1 = 1'b1; addr1 = 64'h0;
      measure(f1, f2);
      chk("post_rst_f1", 64'(f1), 64'd4);
      chk("post_rst_word", rdata1, W0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096: number of 64-bit words in the backing store.
REQ-002 Parameter LATENCY, default 2, legal 1..15: cycles from a granted request to data valid.
REQ-003 Parameter BASE_ADDR, default 64'h0: byte address of word 0.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req1  input  1  port-1 (instruction/page-walk) request pulse.
REQ-007 addr1  input  64  port-1 byte address, sampled in the req1 cycle.
REQ-008 stall1  output  1  port-1 busy: request accepted and data not yet valid.
REQ-009 rdata1  output  64  port-1 read data, valid the cycle stall1 falls and held until the next port-1 grant.
REQ-010 req2  input  1  port-2 (data) request pulse.
REQ-011 addr2  input  64  port-2 byte address, sampled in the req2 cycle.
REQ-012 stall2  output  1  port-2 busy, same meaning as stall1.
REQ-013 rdata2  output  64  port-2 read data, same rules as rdata1.
REQ-014 wr_en  input  1  preload write strobe.
REQ-015 wr_addr  input  64  preload byte address.
REQ-016 wr_data  input  64  preload data.
REQ-017 err  output  1  sticky: an out-of-range access or dropped request occurred.

Function
REQ-018 Word index = (addr - BASE_ADDR) >> 3; addr[2:0] ignored.
REQ-019 An access is in range when BASE_ADDR <= addr and index < DEPTH_WORDS.
- Out-of-range reads return 64'h0 and set err.
- Out-of-range writes are discarded and set err.
REQ-020 Each port has one pending slot (flag plus latched address), set by its req pulse.
REQ-021 A req pulse on a port whose slot is pending, or that is being served, is dropped and sets err.
REQ-022 stallN is registered.
- Rises the cycle after reqN is accepted.
- Stays high while the slot is pending or being served.
REQ-023 FSM states: IDLE, ACCESS, DONE.
REQ-024 IDLE -> ACCESS when any slot is pending.
- Port 1 has fixed priority over port 2.
- On grant: load the cycle counter with LATENCY-1 and record the owner.
REQ-025 ACCESS: counter decrements each cycle; at 0, read the memory word into the owner's rdata register and go to DONE.
REQ-026 DONE, one cycle: clear the owner's slot; the owner's stall falls at the end of this cycle.
- Next state is IDLE.
- Exception: another slot is pending -> grant it directly (DONE -> ACCESS), with no IDLE bubble.
REQ-027 Latency from a req pulse to stall falling is LATENCY+2 cycles when the other port is idle.
REQ-028 Simultaneous req1 and req2 in IDLE: port 1 is served first; port 2 is granted from port 1's DONE cycle.
REQ-029 wr_en is never stalled; it writes in the same cycle.
REQ-030 A write and a read completing in the same cycle to the same word: the read returns the old data.
REQ-031 rdata of the non-owning port never changes.

Reset
REQ-032 While rst is low:
- State = IDLE, counter = 0, both slots cleared.
- stall1 = stall2 = 0; rdata1 = rdata2 = 64'h0; err = 0.
REQ-033 Reset is asserted asynchronously and released synchronously to clk.
REQ-034 Reset mid-ACCESS abandons the access with no rdata update; memory contents are not reset.

Structure
REQ-035 The FSM state enum and the PORT1/PORT2 owner encoding go in the shared package mem_pkg.
REQ-036 The backing store is sub-module mem_array: one synchronous write port and one read port, DEPTH_WORDS x 64.

Verification
REQ-037 Preload word 0 = 64'hDEAD_BEEF_0000_0001 at BASE_ADDR, LATENCY=2; req1 addr1=0x0 -> stall1 high cycles 1-3, falls in cycle 4, rdata1 = 64'hDEAD_BEEF_0000_0001.
REQ-038 req1 (0x8) and req2 (0x10) in the same cycle, words 1 and 2 preloaded -> port 1 completes first; stall2 falls exactly LATENCY+1 cycles later; each rdata holds its own word.
REQ-039 req1 repeated while stall1 is high -> second request dropped, err = 1, rdata1 = first word.
REQ-040 req2 addr2 = BASE_ADDR + 8*DEPTH_WORDS -> rdata2 = 64'h0, err = 1, stall2 timing unchanged.
REQ-041 rst pulled low in ACCESS cycle 1 -> stall1 = 0 and rdata1 = 0 immediately; after release, req1 0x0 returns the preloaded word.
REQ-042 wr_en to word 3 with new data in the same cycle a port-1 read of word 3 completes -> rdata1 = old data; the next read returns the new data.
